// File: rtl/dlfloat_pkg.sv
// DLFloat16 format constants, field layout and the packed operand type
// shared by the multiplier core and the arbiter.
package dlfloat_pkg;

   localparam int DLF_W    = 16;
   localparam int EXP_W    = 6;
   localparam int FRAC_W   = 9;
   localparam int EXP_BIAS = 31;

   localparam int SIGN_IDX = 15;
   localparam int EXP_MSB  = 14;
   localparam int EXP_LSB  = 9;
   localparam int FRAC_MSB = 8;
   localparam int FRAC_LSB = 0;

   localparam logic [DLF_W-1:0] DLF_ZERO    = 16'h0000;
   // Largest finite magnitude; all-ones exponent with all-ones fraction is reserved.
   localparam logic [DLF_W-2:0] DLF_MAX_MAG = 15'h7FFE;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } dlf_t;

   // A zero exponent encodes zero; subnormals are not represented.
   function automatic logic dlf_is_zero(input dlf_t x);
      return (x.exp == 6'd0);
   endfunction

endpackage

// File: rtl/dlfloat_mul_core.sv
// Combinational DLFloat16 multiplier: round-to-nearest-even, flush-to-zero
// on underflow, saturation to the largest finite value on overflow.
module dlfloat_mul_core
   import dlfloat_pkg::*;
(
   input  dlf_t a,
   input  dlf_t b,
   output dlf_t p
);

   logic [9:0]        man_a_s;
   logic [9:0]        man_b_s;
   logic [19:0]       prod_s;
   logic              norm_s;
   logic [8:0]        frac_t_s;
   logic              guard_s;
   logic              sticky_s;
   logic              rnd_up_s;
   logic [9:0]        frac_r_s;
   logic signed [8:0] exp_s;
   logic              sign_s;

   // Multiply significands, normalise, round and pack the result.
   always_comb begin
      sign_s   = a.sign ^ b.sign;
      man_a_s  = {1'b1, a.frac};
      man_b_s  = {1'b1, b.frac};
      prod_s   = {10'd0, man_a_s} * {10'd0, man_b_s};
      norm_s   = prod_s[19];
      if (norm_s) begin
         frac_t_s = prod_s[18:10];
         guard_s  = prod_s[9];
         sticky_s = |prod_s[8:0];
      end else begin
         frac_t_s = prod_s[17:9];
         guard_s  = prod_s[8];
         sticky_s = |prod_s[7:0];
      end
      rnd_up_s = guard_s & (sticky_s | frac_t_s[0]);
      frac_r_s = {1'b0, frac_t_s} + {9'd0, rnd_up_s};
      // A rounding carry out of the fraction leaves frac_r_s[8:0] at zero and bumps the exponent.
      exp_s    = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - 9'sd31
               + $signed({8'd0, norm_s}) + $signed({8'd0, frac_r_s[9]});
      if (dlf_is_zero(a) || dlf_is_zero(b)) begin
         p = DLF_ZERO;
      end else if (exp_s < 9'sd1) begin
         p = DLF_ZERO;
      end else if ((exp_s > 9'sd63) || ((exp_s == 9'sd63) && (frac_r_s[8:0] == 9'h1FF))) begin
         p = {sign_s, DLF_MAX_MAG};
      end else begin
         p = {sign_s, exp_s[5:0], frac_r_s[8:0]};
      end
   end

endmodule

// File: rtl/dlfloat_mul_arbiter.sv
// Round-robin arbiter sharing one DLFloat16 multiplier among NUM_REQ
// requesters through a two-stage pipeline with a tagged, backpressured
// response port.
module dlfloat_mul_arbiter
   import dlfloat_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*16-1:0] req_a,
   input  logic [NUM_REQ*16-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           rsp_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      op_count
);

   logic [ID_W-1:0]  rr_ptr_r;
   logic             s1_v_r;
   logic [ID_W-1:0]  s1_id_r;
   dlf_t             s1_a_r;
   dlf_t             s1_b_r;
   logic             s2_v_r;
   logic [ID_W-1:0]  rsp_id_r;
   logic [15:0]      rsp_data_r;
   logic             busy_r;
   logic [CNT_W-1:0] op_count_r;

   logic             grant_any_s;
   logic [ID_W-1:0]  grant_id_s;
   logic [ID_W-1:0]  rr_next_s;
   logic             s2_free_s;
   logic             s1_adv_s;
   logic             s1_free_s;
   logic             accept_s;
   logic             deliver_s;
   logic             s1_v_next_s;
   logic             s2_v_next_s;
   dlf_t             sel_a_s;
   dlf_t             sel_b_s;
   dlf_t             core_p_s;
   int               idx_v;

   // Round-robin search starting at rr_ptr for the first valid requester.
   always_comb begin
      grant_any_s = 1'b0;
      grant_id_s  = '0;
      idx_v       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v = int'(rr_ptr_r) + k;
         if (idx_v >= NUM_REQ) begin
            idx_v = idx_v - NUM_REQ;
         end else begin
            idx_v = idx_v;
         end
         if (!grant_any_s && req_valid[idx_v]) begin
            grant_any_s = 1'b1;
            grant_id_s  = idx_v[ID_W-1:0];
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

   // Stall/advance handshake, next-pointer and operand selection.
   always_comb begin
      s2_free_s = ~s2_v_r | rsp_ready;
      s1_adv_s  = s1_v_r & s2_free_s;
      s1_free_s = ~s1_v_r | s1_adv_s;
      accept_s  = grant_any_s & s1_free_s & rst_n;
      deliver_s = s2_v_r & rsp_ready;
      if (int'(grant_id_s) == NUM_REQ - 1) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = grant_id_s + {{(ID_W-1){1'b0}}, 1'b1};
      end
      sel_a_s     = req_a[16*int'(grant_id_s) +: 16];
      sel_b_s     = req_b[16*int'(grant_id_s) +: 16];
      s1_v_next_s = accept_s | (s1_v_r & ~s1_adv_s);
      s2_v_next_s = s1_adv_s | (s2_v_r & ~deliver_s);
   end

   // One-hot ready to the granted requester when stage 1 can take it.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept_s && (int'(grant_id_s) == i)) begin
            req_ready[i] = 1'b1;
         end else begin
            req_ready[i] = 1'b0;
         end
      end
   end

   dlfloat_mul_core u_core (
      .a (s1_a_r),
      .b (s1_b_r),
      .p (core_p_s)
   );

   // Pipeline registers, round-robin pointer and delivery counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_r   <= '0;
         s1_v_r     <= 1'b0;
         s1_id_r    <= '0;
         s1_a_r     <= DLF_ZERO;
         s1_b_r     <= DLF_ZERO;
         s2_v_r     <= 1'b0;
         rsp_id_r   <= '0;
         rsp_data_r <= DLF_ZERO;
         busy_r     <= 1'b0;
         op_count_r <= '0;
      end else begin
         s1_v_r <= s1_v_next_s;
         s2_v_r <= s2_v_next_s;
         busy_r <= s1_v_next_s | s2_v_next_s;
         if (accept_s) begin
            s1_id_r  <= grant_id_s;
            s1_a_r   <= sel_a_s;
            s1_b_r   <= sel_b_s;
            rr_ptr_r <= rr_next_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
         if (s1_adv_s) begin
            rsp_id_r   <= s1_id_r;
            rsp_data_r <= core_p_s;
         end else begin
            rsp_id_r   <= rsp_id_r;
         end
         if (deliver_s) begin
            op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            op_count_r <= op_count_r;
         end
      end
   end

   assign rsp_valid = s2_v_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_data  = rsp_data_r;
   assign busy      = busy_r;
   assign op_count  = op_count_r;

endmodule

// File: tb/tb_dlfloat_mul_arbiter.sv
// Directed bench for dlfloat_mul_arbiter: table of single-operation vectors
// plus hand-written round-robin, backpressure, mid-flight reset and
// counter-wrap sequences. Inputs change on the falling edge, outputs are
// sampled 1ns later.
module tb_dlfloat_mul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_a;
   logic [NUM_REQ*16-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [15:0]           rsp_data;
   logic                  busy;
   logic [CNT_W-1:0]      op_count;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   typedef struct {
      int          idx;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   dlfloat_mul_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .op_count  (op_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One-cycle reset taken with the bus still active, then released idle.
   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_gate_ready", req_ready, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_op_count", op_count, 0);
      exp_cnt = 0;
   endtask

   initial begin
      logic [3:0] onehot;
      int         n;
      int         acc;
      int         deliv;
      logic [1:0] ids[$];

      vecs[0] = '{0, 16'h0000, 16'h3F00, 16'h0000};
      vecs[1] = '{2, 16'h3F00, 16'hBF00, 16'hC040};
      vecs[2] = '{1, 16'h3E00, 16'h3E00, 16'h3E00};
      vecs[3] = '{3, 16'h3E00, 16'h4000, 16'h4000};
      vecs[4] = '{0, 16'hBF00, 16'hBF00, 16'h4040};
      vecs[5] = '{1, 16'h0200, 16'h0200, 16'h0000};
      vecs[6] = '{2, 16'h7E00, 16'h7E00, 16'h7FFE};
      vecs[7] = '{3, 16'h3E01, 16'h3F00, 16'h3F02};
      vecs[8] = '{1, 16'h3FFF, 16'h3FFF, 16'h41FE};
      vecs[9] = '{3, 16'h8000, 16'h3F00, 16'h0000};

      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset held with every requester asking.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check("reset_req_ready", req_ready, 0);
         check("reset_rsp_valid", rsp_valid, 0);
         check("reset_op_count", op_count, 0);
         check("reset_busy", busy, 0);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;

      // Single operations from the vector table, checking two-cycle latency.
      for (int v = 0; v < 10; v++) begin
         req_a[16*vecs[v].idx +: 16] = vecs[v].a;
         req_b[16*vecs[v].idx +: 16] = vecs[v].b;
         onehot    = 4'b0001 << vecs[v].idx;
         req_valid = onehot;
         #1;
         n = 0;
         while ((req_ready[vecs[v].idx] !== 1'b1) && (n < 8)) begin
            @(negedge clk);
            #1;
            n++;
         end
         check("vec_ready", req_ready, onehot);
         @(negedge clk);
         req_valid = '0;
         #1;
         check("vec_lat_early", rsp_valid, 0);
         @(negedge clk);
         #1;
         check("vec_rsp_valid", rsp_valid, 1);
         check("vec_rsp_id", rsp_id, vecs[v].idx);
         check("vec_rsp_data", rsp_data, vecs[v].p);
         check("vec_busy", busy, 1);
         @(negedge clk);
         #1;
         exp_cnt++;
         check("vec_op_count", op_count, exp_cnt % 16);
         check("vec_drained", rsp_valid, 0);
         check("vec_idle", busy, 0);
      end

      // Round robin at full throughput; product 1.0 * b_i identifies the requester.
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[16*i +: 16] = 16'h3E00;
         req_b[16*i +: 16] = 16'h4000 + 16'(i);
      end
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         check("rr_grant", req_ready, 1 << (k % 4));
         check("rr_op_count", op_count, exp_cnt % 16);
         if (k >= 2) begin
            check("rr_rsp_valid", rsp_valid, 1);
            check("rr_rsp_id", rsp_id, (k - 2) % 4);
            check("rr_rsp_data", rsp_data, 16'h4000 + 16'((k - 2) % 4));
            exp_cnt++;
         end
      end

      // Backpressure from an empty pipeline: two accepts, then a frozen output.
      pulse_reset();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      #1;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         check("bp_ready", req_ready, (c == 0) ? 1 : ((c == 1) ? 2 : 0));
         if (req_ready != '0) begin
            acc++;
         end
         if (c >= 2) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 0);
            check("bp_rsp_data", rsp_data, 16'h4000);
         end
      end
      check("bp_accepts", acc, 2);
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = '0;
      #1;
      ids.delete();
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid) begin
            ids.push_back(rsp_id);
         end
         @(negedge clk);
         #1;
      end
      check("bp_drain_count", ids.size(), 2);
      if (ids.size() == 2) begin
         check("bp_drain_first", ids[0], 0);
         check("bp_drain_second", ids[1], 1);
      end
      check("bp_drain_idle", busy, 0);
      check("bp_drain_op_count", op_count, 2);

      // Fill both stages (pointer now at requester 2), then reset mid-flight.
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      #1;
      check("mf_grant_first", req_ready, 4'b0100);
      @(negedge clk);
      #1;
      check("mf_grant_second", req_ready, 4'b1000);
      @(negedge clk);
      #1;
      check("mf_full_ready", req_ready, 0);
      check("mf_full_busy", busy, 1);
      pulse_reset();

      // After reset the pointer restarts at 0, discarded ops never appear, and the 4-bit counter wraps.
      acc   = 0;
      deliv = 0;
      for (int c = 0; (c < 40) && (deliv < 16); c++) begin
         @(negedge clk);
         if (c == 0) begin
            req_valid = 4'hF;
         end else if (acc >= 16) begin
            req_valid = '0;
         end
         #1;
         check("wrap_op_count", op_count, deliv % 16);
         if (acc < 16) begin
            check("wrap_grant", req_ready, 1 << (acc % 4));
         end
         if (req_ready != '0) begin
            acc++;
         end
         if (rsp_valid && rsp_ready) begin
            check("wrap_rsp_id", rsp_id, deliv % 4);
            deliv++;
         end
      end
      check("wrap_deliveries", deliv, 16);
      @(negedge clk);
      #1;
      check("wrap_op_count_zero", op_count, 0);
      check("wrap_idle", busy, 0);
      check("wrap_no_extra", rsp_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
